// File: rtl/ram32_port_arbiter_pkg.sv
// Shared types and constants for the two-port block-RAM arbiter.
package ram32_port_arbiter_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int unsigned RAM_DEPTH  = 256;
  localparam int unsigned RD_LATENCY = 1;
  localparam int unsigned DEF_ADDR_W = $clog2(RAM_DEPTH);
  localparam int unsigned DEF_DATA_W = 32;

  // Tie-break winner: whichever port did not win the previous grant.
  function automatic logic rr_winner(input logic last_grant);
    return (last_grant == PORT_B) ? PORT_A : PORT_B;
  endfunction

endpackage

// File: rtl/ram32_port_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; grants are one-hot and combinational,
// last_grant is updated on every grant.
module ram32_port_arbiter_rr_arb2
  import ram32_port_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a_c,
  output logic gnt_b_c
);

  logic last_grant;

  always_comb begin
    gnt_a_c = 1'b0;
    gnt_b_c = 1'b0;
    if (en) begin
      if (req_a && req_b) begin
        if (rr_winner(last_grant) == PORT_A) gnt_a_c = 1'b1;
        else                                 gnt_b_c = 1'b1;
      end else begin
        gnt_a_c = req_a;
        gnt_b_c = req_b;
      end
    end
  end

  // Reset to B so that A wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= PORT_B;
    end else if (gnt_a_c) begin
      last_grant <= PORT_A;
    end else if (gnt_b_c) begin
      last_grant <= PORT_B;
    end
  end

endmodule

// File: rtl/ram32_port_arbiter.sv
// Shares one single-port block RAM between two requesters with round-robin
// arbitration, an optional zero-fill sweep after reset and routed read return.
module ram32_port_arbiter
  import ram32_port_arbiter_pkg::*;
#(
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_wre,
  input  logic [ADDR_W-1:0] a_ad,
  input  logic [DATA_W-1:0] a_din,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_dout,
  input  logic              b_req,
  input  logic              b_wre,
  input  logic [ADDR_W-1:0] b_ad,
  input  logic [DATA_W-1:0] b_din,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_dout,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_reset,
  output logic              ram_wre,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              ready
);

  localparam state_t            RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = '1;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_W-1:0]     clr_addr;
  logic                  arb_en_c;
  logic                  gnt_a_c;
  logic                  gnt_b_c;
  logic [RD_LATENCY-1:0] pend_a;
  logic [RD_LATENCY-1:0] pend_b;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= RESET_STATE;
    else       state <= state_nxt;
  end

  // Next state: the sweep ends after the last address has been written.
  always_comb begin
    state_nxt = state;
    if (state == ST_CLEAR && clr_addr == LAST_ADDR) state_nxt = ST_RUN;
  end

  // Clear-address counter and ready flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_addr <= '0;
      ready    <= ~CLEAR_ON_RESET;
    end else if (state == ST_CLEAR) begin
      clr_addr <= clr_addr + ADDR_W'(1);
      if (clr_addr == LAST_ADDR) ready <= 1'b1;
    end
  end

  assign arb_en_c = !reset && (state == ST_RUN);

  ram32_port_arbiter_rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .en      (arb_en_c),
    .req_a   (a_req),
    .req_b   (b_req),
    .gnt_a_c (gnt_a_c),
    .gnt_b_c (gnt_b_c)
  );

  // RAM command mux: sweep writes while clearing, else the granted port.
  always_comb begin
    ram_ce  = 1'b0;
    ram_wre = 1'b0;
    ram_ad  = '0;
    ram_din = '0;
    if (!reset) begin
      case (state)
        ST_CLEAR: begin
          ram_ce  = 1'b1;
          ram_wre = 1'b1;
          ram_ad  = clr_addr;
        end
        ST_RUN: begin
          if (gnt_a_c) begin
            ram_ce  = 1'b1;
            ram_wre = a_wre;
            ram_ad  = a_ad;
            ram_din = a_din;
          end else if (gnt_b_c) begin
            ram_ce  = 1'b1;
            ram_wre = b_wre;
            ram_ad  = b_ad;
            ram_din = b_din;
          end
        end
        default: ;
      endcase
    end
  end

  // Read-return tracking: one shift stage per cycle of RAM read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_a <= '0;
      pend_b <= '0;
    end else begin
      pend_a <= RD_LATENCY'({pend_a, gnt_a_c & ~a_wre});
      pend_b <= RD_LATENCY'({pend_b, gnt_b_c & ~b_wre});
    end
  end

  // A response in flight when reset arrives is suppressed, not delivered.
  assign a_rvalid  = pend_a[RD_LATENCY-1] & ~reset;
  assign b_rvalid  = pend_b[RD_LATENCY-1] & ~reset;
  assign a_dout    = ram_dout;
  assign b_dout    = ram_dout;
  assign a_gnt     = gnt_a_c;
  assign b_gnt     = gnt_b_c;
  assign ram_oce   = 1'b1;
  assign ram_reset = reset;

endmodule

// File: tb/tb_ram32_port_arbiter.sv
// Bench for ram32_port_arbiter: directed vector table, reset/sweep sequences
// and randomized traffic against a transaction-level memory/arbiter model.
module tb_ram32_port_arbiter;

  logic clk;
  logic reset;

  logic        a_req, a_wre, b_req, b_wre;
  logic [7:0]  a_ad, b_ad;
  logic [31:0] a_din, b_din;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [31:0] a_dout, b_dout;
  logic        ram_ce, ram_oce, ram_reset, ram_wre;
  logic [7:0]  ram_ad;
  logic [31:0] ram_din, ram_dout;
  logic        ready;

  logic        c_a_req;
  logic        c_a_gnt, c_a_rvalid, c_b_gnt, c_b_rvalid;
  logic [31:0] c_a_dout, c_b_dout;
  logic        c_ram_ce, c_ram_oce, c_ram_reset, c_ram_wre;
  logic [7:0]  c_ram_ad;
  logic [31:0] c_ram_din;
  logic [31:0] c_ram_dout;
  logic        c_ready;

  int checks = 0;
  int errors = 0;

  ram32_port_arbiter #(.CLEAR_ON_RESET(1'b1), .ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_wre(a_wre), .a_ad(a_ad), .a_din(a_din),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_dout(a_dout),
    .b_req(b_req), .b_wre(b_wre), .b_ad(b_ad), .b_din(b_din),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_dout(b_dout),
    .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_reset(ram_reset), .ram_wre(ram_wre),
    .ram_ad(ram_ad), .ram_din(ram_din), .ram_dout(ram_dout), .ready(ready)
  );

  ram32_port_arbiter #(.CLEAR_ON_RESET(1'b0), .ADDR_W(8), .DATA_W(32)) dut_nc (
    .clk(clk), .reset(reset),
    .a_req(c_a_req), .a_wre(1'b0), .a_ad(8'h00), .a_din(32'h0),
    .a_gnt(c_a_gnt), .a_rvalid(c_a_rvalid), .a_dout(c_a_dout),
    .b_req(1'b0), .b_wre(1'b0), .b_ad(8'h00), .b_din(32'h0),
    .b_gnt(c_b_gnt), .b_rvalid(c_b_rvalid), .b_dout(c_b_dout),
    .ram_ce(c_ram_ce), .ram_oce(c_ram_oce), .ram_reset(c_ram_reset), .ram_wre(c_ram_wre),
    .ram_ad(c_ram_ad), .ram_din(c_ram_din), .ram_dout(c_ram_dout), .ready(c_ready)
  );

  assign c_ram_dout = 32'h0;

  // Single-port RAM in bypass read mode: data appears the cycle after the read.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_wre) mem[ram_ad] <= ram_din;
      else         ram_dout    <= mem[ram_ad];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic req; logic wre; logic [7:0] ad; logic [31:0] din;
  } req_t;

  typedef struct {
    req_t a; req_t b;
    logic ga; logic gb;
    logic rva; logic [31:0] da;
    logic rvb; logic [31:0] db;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input req_t pa, input req_t pb);
    a_req = pa.req; a_wre = pa.wre; a_ad = pa.ad; a_din = pa.din;
    b_req = pb.req; b_wre = pb.wre; b_ad = pb.ad; b_din = pb.din;
  endtask

  function automatic req_t rq(input logic r, input logic w, input logic [7:0] ad, input logic [31:0] d);
    req_t x;
    x.req = r; x.wre = w; x.ad = ad; x.din = d;
    return x;
  endfunction

  function automatic vec_t mk(input req_t pa, input req_t pb, input logic ga, input logic gb,
                              input logic rva, input logic [31:0] da,
                              input logic rvb, input logic [31:0] db);
    vec_t v;
    v.a = pa; v.b = pb; v.ga = ga; v.gb = gb;
    v.rva = rva; v.da = da; v.rvb = rvb; v.db = db;
    return v;
  endfunction

  // Called right after reset is released; checks the full zero-fill sweep.
  task automatic check_sweep(input bit with_nc);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      chk("clr_ad", 32'(ram_ad), 32'(i));
      chk("clr_wre", 32'(ram_wre & ram_ce), 32'd1);
      chk("clr_din", ram_din, 32'h0);
      chk("clr_ready", 32'(ready), 32'd0);
      chk("clr_a_gnt", 32'(a_gnt), 32'd0);
      chk("clr_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
      if (with_nc && i == 0) begin
        chk("nc_ready", 32'(c_ready), 32'd1);
        chk("nc_first_gnt", 32'(c_a_gnt), 32'd1);
      end
    end
    @(negedge clk);
    chk("ready_after_sweep", 32'(ready), 32'd1);
  endtask

  vec_t tbl[$];
  req_t idle;
  req_t pa, pb;
  logic [31:0] ref_mem [256];
  logic m_last_b;
  logic ea, eb, ga_prev, gb_prev;
  logic erva, ervb;
  logic [31:0] eda, edb;

  initial begin
    idle = rq(1'b0, 1'b0, 8'h00, 32'h0);
    reset = 1'b1;
    drive(rq(1'b1, 1'b0, 8'h00, 32'h0), idle);
    c_a_req = 1'b1;

    // Reset behaviour, then sweep with a_req held throughout.
    for (int k = 0; k < 2; k++) begin
      step();
      @(negedge clk);
      chk("rst_ram_ce", 32'(ram_ce), 32'd0);
      chk("rst_a_gnt", 32'(a_gnt), 32'd0);
      chk("rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_ram_reset", 32'(ram_reset), 32'd1);
      chk("rst_ram_oce", 32'(ram_oce), 32'd1);
      chk("nc_rst_gnt", 32'(c_a_gnt), 32'd0);
      chk("nc_rst_ready", 32'(c_ready), 32'd1);
    end
    step();
    reset = 1'b0;
    check_sweep(1'b1);
    chk("first_run_a_gnt", 32'(a_gnt), 32'd1);
    chk("first_run_wre", 32'(ram_wre), 32'd0);
    step();
    drive(idle, idle);
    c_a_req = 1'b0;
    @(negedge clk);
    chk("first_rd_rvalid", 32'(a_rvalid), 32'd1);
    chk("first_rd_dout", a_dout, 32'h0);
    chk("first_rd_b_rvalid", 32'(b_rvalid), 32'd0);

    // Directed vector table; last grant is A at this point.
    tbl.push_back(mk(rq(1,1,8'h12,32'hDEADBEEF), idle, 1,0, 0,0, 0,0));
    tbl.push_back(mk(rq(1,0,8'h12,0), idle, 1,0, 0,0, 0,0));
    tbl.push_back(mk(idle, idle, 0,0, 1,32'hDEADBEEF, 0,0));
    tbl.push_back(mk(idle, rq(1,1,8'h20,32'h0B0B0020), 0,1, 0,0, 0,0));
    tbl.push_back(mk(rq(1,1,8'h30,32'hA0A0A030), rq(1,1,8'h31,32'hB0B0B031), 1,0, 0,0, 0,0));
    tbl.push_back(mk(rq(1,0,8'h30,0), rq(1,1,8'h31,32'hB0B0B031), 0,1, 0,0, 0,0));
    tbl.push_back(mk(rq(1,0,8'h30,0), rq(1,0,8'h31,0), 1,0, 0,0, 0,0));
    tbl.push_back(mk(rq(1,0,8'h12,0), rq(1,0,8'h31,0), 0,1, 1,32'hA0A0A030, 0,0));
    tbl.push_back(mk(rq(1,0,8'h12,0), rq(1,0,8'h20,0), 1,0, 0,0, 1,32'hB0B0B031));
    tbl.push_back(mk(rq(1,0,8'h31,0), rq(1,0,8'h20,0), 0,1, 1,32'hDEADBEEF, 0,0));
    tbl.push_back(mk(rq(1,0,8'h31,0), idle, 1,0, 0,0, 1,32'h0B0B0020));
    tbl.push_back(mk(idle, idle, 0,0, 1,32'hB0B0B031, 0,0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(idle, rq(1,1,8'(i),32'h100 + 32'(i)), 0,1, 0,0, 0,0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(idle, rq(1,0,8'(i),0), 0,1, 0,0, i > 0, 32'h100 + 32'(i) - 32'd1));
    tbl.push_back(mk(idle, idle, 0,0, 0,0, 1,32'h103));
    tbl.push_back(mk(rq(1,1,8'h44,32'h12345678), idle, 1,0, 0,0, 0,0));
    tbl.push_back(mk(rq(1,0,8'h44,0), idle, 1,0, 0,0, 0,0));
    tbl.push_back(mk(idle, idle, 0,0, 1,32'h12345678, 0,0));

    foreach (tbl[r]) begin
      step();
      drive(tbl[r].a, tbl[r].b);
      @(negedge clk);
      chk($sformatf("v%0d_a_gnt", r), 32'(a_gnt), 32'(tbl[r].ga));
      chk($sformatf("v%0d_b_gnt", r), 32'(b_gnt), 32'(tbl[r].gb));
      chk($sformatf("v%0d_a_rvalid", r), 32'(a_rvalid), 32'(tbl[r].rva));
      chk($sformatf("v%0d_b_rvalid", r), 32'(b_rvalid), 32'(tbl[r].rvb));
      if (tbl[r].rva) chk($sformatf("v%0d_a_dout", r), a_dout, tbl[r].da);
      if (tbl[r].rvb) chk($sformatf("v%0d_b_dout", r), b_dout, tbl[r].db);
    end

    // Fresh reset so the random phase starts from a known memory and tie state.
    step();
    drive(idle, idle);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_sweep(1'b0);

    // Randomized traffic against a transaction-level model.
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    m_last_b = 1'b1;
    ga_prev = 1'b0; gb_prev = 1'b0;
    erva = 1'b0; ervb = 1'b0; eda = 32'h0; edb = 32'h0;
    pa = idle; pb = idle;
    for (int cyc = 0; cyc < 500; cyc++) begin
      step();
      if (!pa.req || ga_prev)
        pa = rq($urandom_range(0,3) != 0, 1'($urandom_range(0,1)), 8'($urandom_range(0,15)), $urandom);
      if (!pb.req || gb_prev)
        pb = rq($urandom_range(0,3) != 0, 1'($urandom_range(0,1)), 8'($urandom_range(0,15)), $urandom);
      drive(pa, pb);
      @(negedge clk);
      ea = pa.req && (!pb.req || m_last_b);
      eb = pb.req && !ea;
      chk("rnd_a_gnt", 32'(a_gnt), 32'(ea));
      chk("rnd_b_gnt", 32'(b_gnt), 32'(eb));
      chk("rnd_a_rvalid", 32'(a_rvalid), 32'(erva));
      chk("rnd_b_rvalid", 32'(b_rvalid), 32'(ervb));
      if (erva) chk("rnd_a_dout", a_dout, eda);
      if (ervb) chk("rnd_b_dout", b_dout, edb);
      erva = 1'b0; ervb = 1'b0;
      if (ea) begin
        if (pa.wre) ref_mem[pa.ad] = pa.din;
        else begin erva = 1'b1; eda = ref_mem[pa.ad]; end
        m_last_b = 1'b0;
      end
      if (eb) begin
        if (pb.wre) ref_mem[pb.ad] = pb.din;
        else begin ervb = 1'b1; edb = ref_mem[pb.ad]; end
        m_last_b = 1'b1;
      end
      ga_prev = ea; gb_prev = eb;
    end
    step();
    drive(idle, idle);
    @(negedge clk);
    chk("rnd_tail_a_rvalid", 32'(a_rvalid), 32'(erva));
    chk("rnd_tail_b_rvalid", 32'(b_rvalid), 32'(ervb));
    if (erva) chk("rnd_tail_a_dout", a_dout, eda);
    if (ervb) chk("rnd_tail_b_dout", b_dout, edb);

    // Reset in the middle of a sweep restarts it from address 0.
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i <= 8'h80; i++) begin
      @(negedge clk);
      chk("mid_ad", 32'(ram_ad), 32'(i));
    end
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_ce", 32'(ram_ce), 32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd0);
    step();
    reset = 1'b0;
    check_sweep(1'b0);

    // Reset one cycle after a read grant: the response must never appear.
    step();
    drive(rq(1,0,8'h12,0), idle);
    @(negedge clk);
    chk("abort_rd_gnt", 32'(a_gnt), 32'd1);
    step();
    drive(idle, idle);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_rvalid", 32'(a_rvalid), 32'd0);
    chk("abort_rst_gnt", 32'(a_gnt), 32'd0);
    step();
    reset = 1'b0;
    check_sweep(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram32_port_arbiter.md
Name: ram32_port_arbiter

Overview:
- Shares the single-port 256x32 block RAM between two requesters: port A (CPU load/store unit) and port B (UART loader / debug access).
- Optionally zero-fills the RAM after reset.
- Grants one access per cycle using round-robin arbitration.
- Returns read data with a 1-cycle latency and routes it to the requester that issued the read.

Parameters:
- CLEAR_ON_RESET, 1: 1 = sweep addresses 0..255 writing zero after reset; 0 = go straight to RUN.
- ADDR_W, 8: word address width; the RAM depth is 2**ADDR_W.
- DATA_W, 32: data width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- a_req  in  1  port A access request; held until granted.
- a_wre  in  1  port A write enable (1 = write, 0 = read).
- a_ad  in  ADDR_W  port A word address.
- a_din  in  DATA_W  port A write data.
- a_gnt  out  1  port A request accepted this cycle.
- a_rvalid  out  1  port A read data valid.
- a_dout  out  DATA_W  port A read data.
- b_req, b_wre, b_ad, b_din, b_gnt, b_rvalid, b_dout: same as the port A signals, for port B.
- ram_ce  out  1  RAM clock enable.
- ram_oce  out  1  RAM output-register enable; tied to 1 (bypass read mode).
- ram_reset  out  1  RAM synchronous reset; equals reset.
- ram_wre  out  1  RAM write enable.
- ram_ad  out  ADDR_W  RAM address.
- ram_din  out  DATA_W  RAM write data.
- ram_dout  in  DATA_W  RAM read data, valid the cycle after the read is issued.
- ready  out  1  high once the clear sweep is complete.

Behaviour:
- Reset values (registered), held while reset=1:
  - state = CLEAR if CLEAR_ON_RESET, else RUN.
  - clr_addr = 0; last_grant = B, so A wins the first tie.
  - rd_pend_a = rd_pend_b = 0; ready = (CLEAR_ON_RESET==0).
  - While reset=1: ram_ce = 0, a_gnt = b_gnt = 0, a_rvalid = b_rvalid = 0. a_dout and b_dout pass ram_dout through and are don't-care when rvalid=0.
- State CLEAR:
  - Outputs: ram_ce=1, ram_wre=1, ram_ad=clr_addr, ram_din=0.
  - Both gnt=0 regardless of req; ready=0.
  - clr_addr increments each cycle. When clr_addr == 2**ADDR_W-1, go to RUN next cycle and set ready=1.
  - Takes exactly 256 cycles at default parameters.
  - A reset asserted mid-sweep restarts the sweep from address 0.
- State RUN, arbitration (combinational within the cycle):
  - Only one of a_req / b_req high: that port is granted.
  - Both high: the port not equal to last_grant wins; last_grant updates to the winner on every grant.
  - Neither high: ram_ce=0, no grant, last_grant unchanged.
- Granted cycle N:
  - ram_ce=1; ram_wre, ram_ad, ram_din muxed from the winner; winner's gnt=1.
  - The requester drops req or presents its next access in cycle N+1.
  - The loser's req stays pending, with no timeout. Strict alternation under continuous contention bounds the wait to 1 cycle.
- Read return:
  - A granted read (wre=0) in cycle N sets rd_pend_<port>=1 for cycle N+1 only.
  - In N+1: <port>_rvalid=1 and <port>_dout = ram_dout.
  - Back-to-back reads give rvalid on consecutive cycles (full throughput, no bubbles).
  - A write in N produces no rvalid. Write-then-read of the same address in N, N+1 returns the new data in N+2.
  - Each port's dout reflects only its own reads; the other port's rvalid stays 0.
- A reset asserted while a read is pending drops rvalid in the next cycle; no stale response is delivered.
- The RAM is never accessed by two sources in one cycle. The arbiter has no internal write buffering.
- No assertion of gnt in the same cycle as reset.

Decomposition:
- Shared package holds:
  - state enum {CLEAR, RUN}
  - port-id constants PORT_A=0, PORT_B=1
  - RAM_DEPTH = 256
  - RD_LATENCY = 1
- One natural sub-module: rr_arb2, a 2-input round-robin arbiter holding last_grant and producing one-hot grants.
- The clear sequencer and read-return tracking stay in the top module.

Test Plan:
- Clear sweep: reset high for 2 cycles, then low → ram_wre=1 with ram_ad 0..255 and ram_din=0 for 256 cycles. ready rises in the cycle after ad=255 is written. a_req held throughout gets a_gnt=0 until ready=1.
- Single-port write/read: A writes 0xDEADBEEF to addr 0x12, then reads 0x12 → a_gnt on both cycles; a_rvalid=1 with a_dout=0xDEADBEEF exactly 1 cycle after the read grant; b_rvalid stays 0.
- Contention: a_req and b_req held high for 6 cycles with distinct addresses → grants alternate A, B, A, B, A, B. Each port's reads return its own data 1 cycle after its own grant.
- Back-to-back reads: B reads addrs 0..3 on consecutive cycles (after writing 0x100+addr to each) → b_rvalid high for 4 consecutive cycles with b_dout = 0x100..0x103.
- Reset mid-operation: assert reset during the clear sweep at addr 0x80 and again one cycle after an A read grant → the sweep restarts at 0, and a_rvalid never asserts for the aborted read.
- CLEAR_ON_RESET=0: after reset release, ready=1 immediately and an a_req is granted in the first cycle.
